// File: rtl/ps2_line_editor.sv
`default_nettype none
// ============================================================================
// Module   : ps2_line_editor
// Purpose  : PS/2 make-code driven line buffer with cursor, backspace,
//            Enter-clear and a registered character read port for VGA text.
// Option   : LINE_EDITOR_AUTOWRAP_EN - a printable key on a full line clears
//            the line and restarts it with that key.
// Revision : 1.0 - initial release
// ============================================================================
module ps2_line_editor #(
   parameter int LINE_LENGTH = 16,
   parameter int COL_WIDTH   = 5
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [7:0]           PS2_code,
   input  logic                 PS2_code_ready,
   input  logic                 PS2_make_code,
   input  logic [COL_WIDTH-1:0] rd_col,
   output logic [5:0]           rd_char_address,
   output logic [COL_WIDTH-1:0] cursor_pos,
   output logic                 line_full,
   output logic                 busy,
   output logic                 key_accepted
);

   localparam logic [COL_WIDTH-1:0] c_LEN   = COL_WIDTH'(LINE_LENGTH);
   localparam logic [COL_WIDTH-1:0] c_LAST  = COL_WIDTH'(LINE_LENGTH - 1);
   localparam logic [COL_WIDTH-1:0] c_ONE   = COL_WIDTH'(1);
   localparam logic [5:0]           c_SPACE = 6'o40;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CLEAR = 2'd1
`ifdef LINE_EDITOR_AUTOWRAP_EN
      ,S_WRAP = 2'd2
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [COL_WIDTH-1:0]   cursor_q, cursor_d;
   logic [COL_WIDTH-1:0]   idx_q, idx_d;
   logic                   ready_q;
   logic [5:0]             buf_q [LINE_LENGTH];
   logic [5:0]             rd_q, rd_d;
   logic                   full_q, busy_q, acc_q, acc_d;
`ifdef LINE_EDITOR_AUTOWRAP_EN
   logic [5:0]             pending_q, pending_d;
   logic                   wrap_q, wrap_d;
`endif

   logic                   key_ev;
   logic [5:0]             dec_code;
   logic                   dec_print, dec_bs, dec_enter;
   logic                   wr_en;
   logic [COL_WIDTH-1:0]   wr_idx;
   logic [5:0]             wr_data;

   assign key_ev = PS2_code_ready & ~ready_q & PS2_make_code;

   always_comb begin
      dec_code  = c_SPACE;
      dec_print = 1'b1;
      dec_bs    = 1'b0;
      dec_enter = 1'b0;
      case (PS2_code)
         8'h45: dec_code = 6'o60;   8'h16: dec_code = 6'o61;
         8'h1E: dec_code = 6'o62;   8'h26: dec_code = 6'o63;
         8'h25: dec_code = 6'o64;   8'h2E: dec_code = 6'o65;
         8'h36: dec_code = 6'o66;   8'h3D: dec_code = 6'o67;
         8'h3E: dec_code = 6'o70;   8'h46: dec_code = 6'o71;
         8'h1C: dec_code = 6'd1;    8'h32: dec_code = 6'd2;
         8'h21: dec_code = 6'd3;    8'h23: dec_code = 6'd4;
         8'h24: dec_code = 6'd5;    8'h2B: dec_code = 6'd6;
         8'h34: dec_code = 6'd7;    8'h33: dec_code = 6'd8;
         8'h43: dec_code = 6'd9;    8'h3B: dec_code = 6'd10;
         8'h42: dec_code = 6'd11;   8'h4B: dec_code = 6'd12;
         8'h3A: dec_code = 6'd13;   8'h31: dec_code = 6'd14;
         8'h44: dec_code = 6'd15;   8'h4D: dec_code = 6'd16;
         8'h15: dec_code = 6'd17;   8'h2D: dec_code = 6'd18;
         8'h1B: dec_code = 6'd19;   8'h2C: dec_code = 6'd20;
         8'h3C: dec_code = 6'd21;   8'h2A: dec_code = 6'd22;
         8'h1D: dec_code = 6'd23;   8'h22: dec_code = 6'd24;
         8'h35: dec_code = 6'd25;   8'h1A: dec_code = 6'd26;
         8'h29: dec_code = c_SPACE;
         8'h66: begin dec_print = 1'b0; dec_bs    = 1'b1; end
         8'h5A: begin dec_print = 1'b0; dec_enter = 1'b1; end
         default: dec_print = 1'b0;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      cursor_d = cursor_q;
      idx_d    = idx_q;
      acc_d    = 1'b0;
      wr_en    = 1'b0;
      wr_idx   = cursor_q;
      wr_data  = c_SPACE;
`ifdef LINE_EDITOR_AUTOWRAP_EN
      pending_d = pending_q;
      wrap_d    = wrap_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (key_ev) begin
               if (dec_print && (cursor_q < c_LEN)) begin
                  wr_en    = 1'b1;
                  wr_data  = dec_code;
                  cursor_d = cursor_q + c_ONE;
                  acc_d    = 1'b1;
               end
`ifdef LINE_EDITOR_AUTOWRAP_EN
               else if (dec_print) begin
                  pending_d = dec_code;
                  wrap_d    = 1'b1;
                  idx_d     = '0;
                  state_d   = S_CLEAR;
                  acc_d     = 1'b1;
               end
`endif
               else if (dec_bs && (cursor_q != '0)) begin
                  wr_en    = 1'b1;
                  wr_idx   = cursor_q - c_ONE;
                  cursor_d = cursor_q - c_ONE;
                  acc_d    = 1'b1;
               end else if (dec_enter) begin
                  idx_d   = '0;
                  state_d = S_CLEAR;
                  acc_d   = 1'b1;
               end
            end
         end
         S_CLEAR: begin
            wr_en  = 1'b1;
            wr_idx = idx_q;
            idx_d  = idx_q + c_ONE;
            if (idx_q == c_LAST) begin
               idx_d    = '0;
               cursor_d = '0;
               state_d  = S_IDLE;
`ifdef LINE_EDITOR_AUTOWRAP_EN
               if (wrap_q) state_d = S_WRAP;
`endif
            end
         end
`ifdef LINE_EDITOR_AUTOWRAP_EN
         S_WRAP: begin
            wr_en    = 1'b1;
            wr_idx   = '0;
            wr_data  = pending_q;
            cursor_d = c_ONE;
            wrap_d   = 1'b0;
            state_d  = S_IDLE;
         end
`endif
         default: state_d = S_IDLE;
      endcase
   end

   // Out-of-range columns fall through to the space default.
   always_comb begin
      rd_d = c_SPACE;
      for (int i = 0; i < LINE_LENGTH; i++) begin
         if (rd_col == COL_WIDTH'(i)) rd_d = buf_q[i];
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= S_IDLE;
         cursor_q <= '0;
         idx_q    <= '0;
         ready_q  <= 1'b0;
         rd_q     <= c_SPACE;
         full_q   <= 1'b0;
         busy_q   <= 1'b0;
         acc_q    <= 1'b0;
         for (int i = 0; i < LINE_LENGTH; i++) buf_q[i] <= c_SPACE;
`ifdef LINE_EDITOR_AUTOWRAP_EN
         pending_q <= c_SPACE;
         wrap_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         cursor_q <= cursor_d;
         idx_q    <= idx_d;
         ready_q  <= PS2_code_ready;
         rd_q     <= rd_d;
         full_q   <= (cursor_d == c_LEN);
         busy_q   <= (state_d == S_CLEAR);
         acc_q    <= acc_d;
         for (int i = 0; i < LINE_LENGTH; i++) begin
            if (wr_en && (wr_idx == COL_WIDTH'(i))) buf_q[i] <= wr_data;
         end
`ifdef LINE_EDITOR_AUTOWRAP_EN
         pending_q <= pending_d;
         wrap_q    <= wrap_d;
`endif
      end
   end

   assign rd_char_address = rd_q;
   assign cursor_pos      = cursor_q;
   assign line_full       = full_q;
   assign busy            = busy_q;
   assign key_accepted    = acc_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_line_editor.sv
`default_nettype none
// ============================================================================
// Module   : tb_ps2_line_editor
// Purpose  : Directed scoreboard bench for ps2_line_editor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ps2_line_editor;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic [7:0] PS2_code = 8'h00;
   logic       PS2_code_ready = 1'b0;
   logic       PS2_make_code = 1'b0;
   logic [4:0] rd_col = 5'd0;
   logic [5:0] rd_char_address;
   logic [4:0] cursor_pos;
   logic       line_full, busy, key_accepted;

   int tests = 0;
   int fails = 0;

   int         pulse_q [$];
   logic [5:0] rdexp_q [$];
   logic       rd_req = 1'b0;
   logic       req_s;
   int         exp_p;
   logic [5:0] exp_r;

   ps2_line_editor #(.LINE_LENGTH(16), .COL_WIDTH(5)) dut (
      .clock          (clock),
      .reset          (reset),
      .PS2_code       (PS2_code),
      .PS2_code_ready (PS2_code_ready),
      .PS2_make_code  (PS2_make_code),
      .rd_col         (rd_col),
      .rd_char_address(rd_char_address),
      .cursor_pos     (cursor_pos),
      .line_full      (line_full),
      .busy           (busy),
      .key_accepted   (key_accepted)
   );

   always #10 clock = ~clock;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0o expected %0o (octal)", name, act, exp);
      end
   endtask

   // Monitor: a key_accepted pulse pops the expected cursor; a read request
   // issued in the previous cycle pops the expected character.
   always @(posedge clock) begin
      req_s = rd_req;
      #1;
      if (key_accepted) begin
         if (pulse_q.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL pulse: unexpected key_accepted, cursor_pos=%0d expected no pulse", cursor_pos);
         end else begin
            exp_p = pulse_q.pop_front();
            chk("pulse_cursor", int'(cursor_pos), exp_p);
         end
      end
      if (req_s) begin
         exp_r = rdexp_q.pop_front();
         chk("rd_char", int'(rd_char_address), int'(exp_r));
      end
   end

   task automatic press(input logic [7:0] code, input logic make, input bit acc, input int exp_cur);
      @(negedge clock);
      PS2_code       = code;
      PS2_make_code  = make;
      PS2_code_ready = 1'b1;
      if (acc) pulse_q.push_back(exp_cur);
      @(negedge clock);
      PS2_code_ready = 1'b0;
   endtask

   task automatic rd(input logic [4:0] col, input logic [5:0] exp);
      @(negedge clock);
      rd_col = col;
      rd_req = 1'b1;
      rdexp_q.push_back(exp);
      @(negedge clock);
      rd_req = 1'b0;
   endtask

   // Counts busy cycles and fires a key mid-clear that must be dropped.
   task automatic wait_clear(output int n);
      n = 0;
      while (busy && n < 40) begin
         n++;
         if (n == 5) begin
            PS2_code = 8'h1C; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
         end
         if (n == 6) PS2_code_ready = 1'b0;
         @(negedge clock);
      end
   endtask

   initial begin
      int n;
      repeat (3) @(negedge clock);
      chk("rst_cursor", int'(cursor_pos), 0);
      chk("rst_full", int'(line_full), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_acc", int'(key_accepted), 0);
      chk("rst_rd", int'(rd_char_address), 'o40);
      reset = 1'b0;

      press(8'h16, 1, 1, 1);
      press(8'h1E, 1, 1, 2);
      press(8'h26, 1, 1, 3);
      chk("cursor_3", int'(cursor_pos), 3);
      rd(0, 6'o61); rd(1, 6'o62); rd(2, 6'o63); rd(3, 6'o40);

      press(8'h66, 1, 1, 2);
      press(8'h66, 1, 1, 1);
      press(8'h66, 1, 1, 0);
      press(8'h66, 1, 0, 0);
      chk("bs_cursor", int'(cursor_pos), 0);
      rd(0, 6'o40); rd(1, 6'o40); rd(2, 6'o40);

      press(8'h16, 0, 0, 0);
      @(negedge clock);
      PS2_code = 8'h45; PS2_make_code = 1'b1; PS2_code_ready = 1'b1;
      pulse_q.push_back(1);
      repeat (10) @(negedge clock);
      PS2_code_ready = 1'b0;
      chk("hold_cursor", int'(cursor_pos), 1);
      rd(0, 6'o60); rd(1, 6'o40);

      press(8'h5A, 1, 1, 1);
      wait_clear(n);
      chk("clear_len1", n, 16);
      chk("clear_cursor1", int'(cursor_pos), 0);

      for (int i = 0; i < 16; i++) press(8'h1C, 1, 1, i + 1);
      chk("full_flag", int'(line_full), 1);
      chk("full_cursor", int'(cursor_pos), 16);
      rd(15, 6'o01); rd(16, 6'o40); rd(31, 6'o40);

`ifdef LINE_EDITOR_AUTOWRAP_EN
      press(8'h32, 1, 1, 16);
      wait_clear(n);
      chk("wrap_clear_len", n, 16);
      @(negedge clock);
      chk("wrap_cursor", int'(cursor_pos), 1);
      chk("wrap_full", int'(line_full), 0);
      rd(0, 6'o02); rd(1, 6'o40);
      press(8'h5A, 1, 1, 1);
`else
      press(8'h32, 1, 0, 0);
      @(negedge clock);
      chk("ovf_cursor", int'(cursor_pos), 16);
      chk("ovf_full", int'(line_full), 1);
      rd(0, 6'o01);
      press(8'h5A, 1, 1, 16);
`endif
      wait_clear(n);
      chk("clear_len2", n, 16);
      chk("clear_cursor2", int'(cursor_pos), 0);
      chk("clear_full", int'(line_full), 0);
      for (int i = 0; i < 16; i++) rd(5'(i), 6'o40);

      for (int i = 0; i < 12; i++) press(8'h1C, 1, 1, i + 1);
      @(negedge clock);
      rd_col = 5'd10;
      press(8'h5A, 1, 1, 12);
      repeat (4) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      chk("midrst_busy", int'(busy), 0);
      chk("midrst_cursor", int'(cursor_pos), 0);
      chk("midrst_rd", int'(rd_char_address), 'o40);
      reset = 1'b0;
      press(8'h1E, 1, 1, 1);
      rd(0, 6'o62); rd(10, 6'o40);

      repeat (3) @(negedge clock);
      chk("pulses_left", pulse_q.size(), 0);
      chk("reads_left", rdexp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/ps2_line_editor.md
Name: ps2_line_editor

Overview:
- Keystroke-driven text line buffer between PS2_controller and the character ROM path of the VGA text display.
- Captures make codes and decodes them to character ROM addresses. Maintains a LINE_LENGTH-entry line with a cursor, supporting append, backspace and Enter-clear.
- Provides a registered read port so the pixel pipeline can fetch the character at any column of the line.

Parameters:
- LINE_LENGTH, 16: number of character cells in the line (2..31).
- COL_WIDTH, 5: width of column and cursor indices; must satisfy 2^COL_WIDTH > LINE_LENGTH.

Ports:
- clock  in  1  50 MHz system clock.
- reset  in  1  synchronous, active-high reset.
- PS2_code  in  8  scan code from PS2_controller.
- PS2_code_ready  in  1  level; a new code is present on its rising edge.
- PS2_make_code  in  1  high when PS2_code is a make code.
- rd_col  in  COL_WIDTH  column requested by the display pipeline.
- rd_char_address  out  6  ROM address of the character at rd_col (registered).
- cursor_pos  out  COL_WIDTH  number of characters in the line (0..LINE_LENGTH).
- line_full  out  1  high when cursor_pos == LINE_LENGTH.
- busy  out  1  high while in the CLEAR state.
- key_accepted  out  1  one-cycle pulse when a keystroke modifies the line.

Behaviour:
- Reset is synchronous and active-high; one clock, with all state updated on the rising edge of clock.
- Reset values:
  - every buffer entry = 6'o40 (space); cursor_pos = 0; state = IDLE.
  - rd_char_address = 6'o40; line_full = 0; busy = 0; key_accepted = 0.
  - ready_q = 0; clear index = 0.
- Event detection:
  - ready_q <= PS2_code_ready.
  - A key event occurs when PS2_code_ready & ~ready_q & PS2_make_code.
  - Break codes are never events.
- Decode table (combinational on PS2_code):
  - Digits: 45,16,1E,26,25,2E,36,3D,3E,46 -> 6'o60..6'o71.
  - Letters A..Z: 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A -> 6'o01..6'o32.
  - 29 -> space 6'o40.
  - 66 = BACKSPACE; 5A = ENTER.
  - Any other code is ignored, with no state change and no pulse.
- FSM states: IDLE, CLEAR, WRAP (WRAP exists only with the optional feature).
- IDLE, on a key event:
  - Printable with cursor_pos < LINE_LENGTH: buf[cursor_pos] <= code; cursor_pos++; key_accepted = 1 in the next cycle.
  - Printable with line full: ignored (see Optional Feature).
  - BACKSPACE with cursor_pos > 0: cursor_pos--; buf[cursor_pos-1] <= 6'o40; pulse.
  - BACKSPACE at cursor_pos == 0: no effect, no pulse.
  - ENTER: go to CLEAR with clear index = 0; pulse.
- CLEAR:
  - Each cycle: buf[idx] <= 6'o40; idx++.
  - At idx == LINE_LENGTH-1, after that write: cursor_pos <= 0; state goes to IDLE, or to WRAP if a wrap is pending.
  - CLEAR lasts exactly LINE_LENGTH cycles. busy = 1 for the whole state.
  - Key events arriving during CLEAR or WRAP are dropped.
- Read port:
  - rd_char_address <= (rd_col < LINE_LENGTH) ? buf[rd_col] : 6'o40.
  - Latency is 1 cycle. The port is always serviced, independent of the FSM.
  - A same-cycle write to the column being read returns the old value; the new value appears one cycle later.
  - During CLEAR the port returns the partially cleared contents.
- line_full and busy are registered, derived from next-state values, so they are valid in the cycle after the change.
- Reset asserted in any state (including mid-CLEAR) forces the reset values on the next edge.

Optional Feature:
- Macro: LINE_EDITOR_AUTOWRAP_EN.
- Defined: a printable key event while the line is full does the following:
  - latches the decoded code into pending_char and enters CLEAR;
  - after CLEAR, the FSM enters WRAP for one cycle: buf[0] <= pending_char; cursor_pos <= 1; return to IDLE.
  - key_accepted pulses once, in the cycle after the event.
- Not defined: the WRAP state and pending_char register are absent, and a printable key on a full line is ignored with no pulse.

Test Plan:
- Reset, then make codes 16,1E,26 (each with a ready rising edge) -> cursor_pos = 3. rd_col = 0,1,2 return 6'o61, 6'o62, 6'o63 one cycle later. rd_col = 3 returns 6'o40.
- Break sequence (PS2_make_code = 0, code 16); ready held high for 10 cycles with a single make 45 -> exactly one entry written (6'o60) and one key_accepted pulse.
- After 3 characters, send 66 four times -> cursor_pos = 2,1,0,0. Entries 0..2 = 6'o40. Exactly 3 pulses.
- Fill 16 chars with 1C ('A' = 6'o01) -> line_full = 1. Send 5A -> busy high for exactly 16 cycles. A key sent mid-CLEAR is dropped. Afterwards cursor_pos = 0 and all reads return 6'o40.
- Full line, then key 32 -> without the macro: no change and no pulse. With LINE_LENGTH_AUTOWRAP_EN... corrected: with LINE_EDITOR_AUTOWRAP_EN defined: 16-cycle clear, then buf[0] = 6'o02 and cursor_pos = 1.
- Assert reset in the 5th cycle of CLEAR -> next edge: busy = 0, cursor_pos = 0, rd_char_address = 6'o40.
